pipeline_hazard_ctrl: RTL and testbench

//  Drives the ID/EX register's flush and flush_fwd pins, and the PC and IF/ID stall/flush controls.
//  - Load-use hazards: stalls PC and IF/ID and inserts bubbles into ID/EX via flush_fwd.
//  - EX-resolved branch mispredicts: flushes IF/ID and ID/EX while the corrected PC loads.
//  - Keeps saturating stall and flush performance counters.

---
 rtl/hazard_pkg.sv | 45 ++++
 rtl/ld_use_detect.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   // Controller states; the 2'b11 encoding is illegal and recovers to HZ_RUN.
   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_LU_STALL = 2'd1,
      HZ_REDIRECT = 2'd2
   } hz_state_t;

   // Architectural zero register: never a real producer.
   localparam logic [4:0] REG_X0 = 5'd0;

   // Pipeline control bundle driven to PC, IF/ID and ID/EX.
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_flush;
      logic idex_flush_fwd;
   } hz_ctrl_t;

   // Normal flow: everything advances, nothing is cleared.
   localparam hz_ctrl_t CTRL_RUN   = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                       idex_flush: 1'b0, idex_flush_fwd: 1'b0};
   // Load-use bubble: hold PC and IF/ID, inject a bubble into ID/EX.
   localparam hz_ctrl_t CTRL_LU    = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                       idex_flush: 1'b0, idex_flush_fwd: 1'b1};
   // Mispredict squash: PC loads the corrected target, younger stages cleared.
   localparam hz_ctrl_t CTRL_FLUSH = '{pc_en: 1'b1, ifid_en: 1'b0, ifid_flush: 1'b1,
                                       idex_flush: 1'b1, idex_flush_fwd: 1'b0};
   // Reset: freeze PC, clear both pipeline registers.
   localparam hz_ctrl_t CTRL_RESET = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
                                       idex_flush: 1'b1, idex_flush_fwd: 1'b0};

   // Down-counter preload for a multi-cycle event: the first cycle is spent
   // in the state that detected the event, so the counter covers cyc-1 more.
   function automatic logic [1:0] cnt_init(input int cyc);
      if (cyc > 1) begin
         return 2'(cyc - 2);
      end
      return 2'd0;
   endfunction

endpackage

// File: rtl/ld_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Also usable by the forwarding unit.
module ld_use_detect
   import hazard_pkg::*;
(
   input  logic       i_id_valid,
   input  logic [4:0] i_id_rs1_addr,
   input  logic [4:0] i_id_rs2_addr,
   input  logic       i_id_rs1_used,
   input  logic       i_id_rs2_used,
   input  logic [4:0] i_ex_rd_addr,
   input  logic       i_ex_isload,
   output logic       o_lu_hit
);

   logic rs1_match;
   logic rs2_match;

   // Source matches only count when the instruction actually reads that source.
   always_comb begin
      rs1_match = i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr);
      rs2_match = i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr);
      o_lu_hit  = i_id_valid && i_ex_isload && (i_ex_rd_addr != REG_X0) &&
                  (rs1_match || rs2_match);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, mispredict flushes and
// saturating stall/flush performance counters. Outputs are combinational
// from state and inputs; ID/EX, IF/ID and PC sample them on the next edge.
// Legal parameter ranges: LOAD_USE_CYC 1..4, REDIRECT_CYC 1..4.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int LOAD_USE_CYC = 1,
   parameter int REDIRECT_CYC = 1,
   parameter int CNT_W        = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_id_valid,
   input  logic [4:0]       i_id_rs1_addr,
   input  logic [4:0]       i_id_rs2_addr,
   input  logic             i_id_rs1_used,
   input  logic             i_id_rs2_used,
   input  logic [4:0]       i_ex_rd_addr,
   input  logic             i_ex_isload,
   input  logic             i_ex_mispred,
   output logic             o_pc_en,
   output logic             o_ifid_en,
   output logic             o_ifid_flush,
   output logic             o_idex_flush,
   output logic             o_idex_flush_fwd,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt,
   output logic [1:0]       o_dbg_state
);

   localparam logic [1:0] LU_INIT = cnt_init(LOAD_USE_CYC);
   localparam logic [1:0] RD_INIT = cnt_init(REDIRECT_CYC);

   hz_state_t        state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   hz_ctrl_t         ctrl;
   logic             lu_hit;

   ld_use_detect u_ld_use_detect (
      .i_id_valid    (i_id_valid),
      .i_id_rs1_addr (i_id_rs1_addr),
      .i_id_rs2_addr (i_id_rs2_addr),
      .i_id_rs1_used (i_id_rs1_used),
      .i_id_rs2_used (i_id_rs2_used),
      .i_ex_rd_addr  (i_ex_rd_addr),
      .i_ex_isload   (i_ex_isload),
      .o_lu_hit      (lu_hit)
   );

   // Next state and control outputs; a mispredict overrides everything,
   // including a same-cycle load-use hit on the instruction being squashed.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctrl    = CTRL_RUN;
      if (i_ex_mispred) begin
         ctrl    = CTRL_FLUSH;
         state_d = (REDIRECT_CYC > 1) ? HZ_REDIRECT : HZ_RUN;
         cnt_d   = RD_INIT;
      end else begin
         case (state_q)
            HZ_RUN: begin
               if (lu_hit) begin
                  ctrl = CTRL_LU;
                  if (LOAD_USE_CYC > 1) begin
                     state_d = HZ_LU_STALL;
                     cnt_d   = LU_INIT;
                  end
               end
            end
            HZ_LU_STALL: begin
               // EX holds a bubble here, so the hit is not re-evaluated.
               ctrl = CTRL_LU;
               if (cnt_q == 2'd0) begin
                  state_d = HZ_RUN;
               end else begin
                  cnt_d = cnt_q - 2'd1;
               end
            end
            HZ_REDIRECT: begin
               ctrl = CTRL_FLUSH;
               if (cnt_q == 2'd0) begin
                  state_d = HZ_RUN;
               end else begin
                  cnt_d = cnt_q - 2'd1;
               end
            end
            default: begin
               state_d = HZ_RUN;
               cnt_d   = 2'd0;
            end
         endcase
      end
      if (i_rst) begin
         ctrl = CTRL_RESET;
      end
   end

   // Saturating performance counters; reset cycles are never counted.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!ctrl.pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (i_ex_mispred && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   // State, down-counter and performance counter registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= HZ_RUN;
         cnt_q       <= 2'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign o_pc_en          = ctrl.pc_en;
   assign o_ifid_en        = ctrl.ifid_en;
   assign o_ifid_flush     = ctrl.ifid_flush;
   assign o_idex_flush     = ctrl.idex_flush;
   assign o_idex_flush_fwd = ctrl.idex_flush_fwd;
   assign o_stall_cnt      = stall_cnt_q;
   assign o_flush_cnt      = flush_cnt_q;
   assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances with different stall and
// redirect lengths share one set of inputs. Expected output vectors are
// queued as stimulus is driven and popped when outputs are sampled.
module tb_pipeline_hazard_ctrl;

   // Output vector order: {pc_en, ifid_en, ifid_flush, idex_flush, idex_flush_fwd}
   localparam logic [4:0] E_RUN = 5'b11000;
   localparam logic [4:0] E_LU  = 5'b00001;
   localparam logic [4:0] E_FL  = 5'b10110;
   localparam logic [4:0] E_RST = 5'b00110;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, rs1_used, rs2_used, ex_isload, ex_mispred;
   logic [4:0] rs1_addr, rs2_addr, ex_rd_addr;

   logic        pc1, ife1, iff1, idf1, fwd1;
   logic        pc2, ife2, iff2, idf2, fwd2;
   logic        pc3, ife3, iff3, idf3, fwd3;
   logic [31:0] stall1, flush1, stall2, flush2, stall3, flush3;
   logic [1:0]  dbg1, dbg2, dbg3;

   wire [4:0]  o1 = {pc1, ife1, iff1, idf1, fwd1};
   wire [4:0]  o2 = {pc2, ife2, iff2, idf2, fwd2};
   wire [4:0]  o3 = {pc3, ife3, iff3, idf3, fwd3};
   wire [14:0] o_all = {o1, o2, o3};

   int n_checks = 0;
   int n_fail   = 0;
   logic [14:0] exp_q[$];

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   pipeline_hazard_ctrl #(.LOAD_USE_CYC(1), .REDIRECT_CYC(1), .CNT_W(32)) u1 (
      .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
      .i_id_rs1_addr(rs1_addr), .i_id_rs2_addr(rs2_addr),
      .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
      .i_ex_rd_addr(ex_rd_addr), .i_ex_isload(ex_isload), .i_ex_mispred(ex_mispred),
      .o_pc_en(pc1), .o_ifid_en(ife1), .o_ifid_flush(iff1), .o_idex_flush(idf1),
      .o_idex_flush_fwd(fwd1), .o_stall_cnt(stall1), .o_flush_cnt(flush1), .o_dbg_state(dbg1));

   pipeline_hazard_ctrl #(.LOAD_USE_CYC(2), .REDIRECT_CYC(2), .CNT_W(32)) u2 (
      .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
      .i_id_rs1_addr(rs1_addr), .i_id_rs2_addr(rs2_addr),
      .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
      .i_ex_rd_addr(ex_rd_addr), .i_ex_isload(ex_isload), .i_ex_mispred(ex_mispred),
      .o_pc_en(pc2), .o_ifid_en(ife2), .o_ifid_flush(iff2), .o_idex_flush(idf2),
      .o_idex_flush_fwd(fwd2), .o_stall_cnt(stall2), .o_flush_cnt(flush2), .o_dbg_state(dbg2));

   pipeline_hazard_ctrl #(.LOAD_USE_CYC(3), .REDIRECT_CYC(1), .CNT_W(32)) u3 (
      .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
      .i_id_rs1_addr(rs1_addr), .i_id_rs2_addr(rs2_addr),
      .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
      .i_ex_rd_addr(ex_rd_addr), .i_ex_isload(ex_isload), .i_ex_mispred(ex_mispred),
      .o_pc_en(pc3), .o_ifid_en(ife3), .o_ifid_flush(iff3), .o_idex_flush(idf3),
      .o_idex_flush_fwd(fwd3), .o_stall_cnt(stall3), .o_flush_cnt(flush3), .o_dbg_state(dbg3));

   // driver tasks
   task automatic drive_raw(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                            input logic u1s, input logic u2s, input logic [4:0] rd,
                            input logic ld, input logic mp);
      @(posedge clk);
      #1;
      id_valid   = v;
      rs1_addr   = r1;
      rs2_addr   = r2;
      rs1_used   = u1s;
      rs2_used   = u2s;
      ex_rd_addr = rd;
      ex_isload  = ld;
      ex_mispred = mp;
   endtask

   // 0 idle, 1 lw x5 / add x6,x5,x1, 2 mispredict, 3 load-use plus mispredict
   task automatic drive_kind(input int k);
      case (k)
         1:       drive_raw(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
         2:       drive_raw(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
         3:       drive_raw(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
         default: drive_raw(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      endcase
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #1;
      rst = 1'b1;
      id_valid = 1'b0; rs1_used = 1'b0; rs2_used = 1'b0;
      ex_isload = 1'b0; ex_mispred = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Reset values, then a one-cycle reset in the middle of REDIRECT.
   task automatic test_reset();
      logic [14:0] e;
      @(negedge clk);
      e = {E_RST, E_RST, E_RST};
      n_checks++;
      if (o_all !== e) begin
         n_fail++; $display("FAIL reset_outputs: got %b expected %b", o_all, e);
      end
      n_checks++;
      if ({stall1, flush1, stall2, flush2, stall3, flush3} !== 192'd0) begin
         n_fail++; $display("FAIL reset_counters: got %0d %0d %0d %0d expected 0", stall1, flush1, stall2, flush2);
      end
      n_checks++;
      if ({dbg1, dbg2, dbg3} !== 6'd0) begin
         n_fail++; $display("FAIL reset_state: got %b expected 000000", {dbg1, dbg2, dbg3});
      end
      // mispredict takes u2 into REDIRECT
      exp_q.push_back({E_FL, E_FL, E_FL});
      drive_kind(2);
      rst = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (o_all !== e) begin
         n_fail++; $display("FAIL rst_mid_c1: got %b expected %b", o_all, e);
      end
      // reset for one cycle while u2 sits in REDIRECT
      exp_q.push_back({E_RST, E_RST, E_RST});
      drive_kind(0);
      rst = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (o_all !== e) begin
         n_fail++; $display("FAIL rst_mid_c2: got %b expected %b", o_all, e);
      end
      n_checks++;
      if (dbg2 !== 2'd2 || flush2 !== 32'd1) begin
         n_fail++; $display("FAIL rst_mid_in_redirect: got state %0d flush %0d expected state 2 flush 1", dbg2, flush2);
      end
      exp_q.push_back({E_RUN, E_RUN, E_RUN});
      drive_kind(0);
      rst = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (o_all !== e) begin
         n_fail++; $display("FAIL rst_mid_c3: got %b expected %b", o_all, e);
      end
      n_checks++;
      if (dbg2 !== 2'd0 || stall2 !== 32'd0 || flush2 !== 32'd0) begin
         n_fail++; $display("FAIL rst_mid_after: got state %0d stall %0d flush %0d expected 0 0 0", dbg2, stall2, flush2);
      end
   endtask

   // Single load-use hazard seen by 1-, 2- and 3-bubble instances.
   task automatic test_load_use();
      int          kinds[4] = '{1, 0, 0, 0};
      logic [14:0] exps[4]  = '{{E_LU, E_LU, E_LU}, {E_RUN, E_LU, E_LU},
                                {E_RUN, E_RUN, E_LU}, {E_RUN, E_RUN, E_RUN}};
      logic [14:0] e;
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(exps[i]);
         drive_kind(kinds[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (o_all !== e) begin
            n_fail++; $display("FAIL load_use_c%0d: got %b expected %b", i, o_all, e);
         end
      end
      n_checks++;
      if (stall1 !== 32'd1 || stall2 !== 32'd2 || stall3 !== 32'd3) begin
         n_fail++; $display("FAIL load_use_stall_cnt: got %0d %0d %0d expected 1 2 3", stall1, stall2, stall3);
      end
   endtask

   // Patterns that must not stall, then an rs2-only hit.
   task automatic test_no_stall();
      logic [14:0] e;
      reset_dut();
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: begin exp_q.push_back({E_RUN, E_RUN, E_RUN}); drive_raw(1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0); end
            1: begin exp_q.push_back({E_RUN, E_RUN, E_RUN}); drive_raw(1, 5'd5, 5'd7, 0, 1, 5'd5, 1, 0); end
            2: begin exp_q.push_back({E_RUN, E_RUN, E_RUN}); drive_raw(0, 5'd5, 5'd5, 1, 1, 5'd5, 1, 0); end
            3: begin exp_q.push_back({E_RUN, E_RUN, E_RUN}); drive_raw(1, 5'd5, 5'd5, 1, 1, 5'd5, 0, 0); end
            4: begin exp_q.push_back({E_LU, E_LU, E_LU});    drive_raw(1, 5'd3, 5'd9, 0, 1, 5'd9, 1, 0); end
            default: begin exp_q.push_back({E_RUN, E_LU, E_LU}); drive_kind(0); end
         endcase
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (o_all !== e) begin
            n_fail++; $display("FAIL no_stall_p%0d: got %b expected %b", i, o_all, e);
         end
      end
      n_checks++;
      if (stall1 !== 32'd1 || stall2 !== 32'd1) begin
         n_fail++; $display("FAIL no_stall_cnt: got %0d %0d expected 1 1", stall1, stall2);
      end
   endtask

   // Single mispredict with 1- and 2-cycle redirect.
   task automatic test_redirect();
      int          kinds[3] = '{2, 0, 0};
      logic [14:0] exps[3]  = '{{E_FL, E_FL, E_FL}, {E_RUN, E_FL, E_RUN}, {E_RUN, E_RUN, E_RUN}};
      logic [14:0] e;
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(exps[i]);
         drive_kind(kinds[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (o_all !== e) begin
            n_fail++; $display("FAIL redirect_c%0d: got %b expected %b", i, o_all, e);
         end
      end
      n_checks++;
      if (flush1 !== 32'd1 || flush2 !== 32'd1 || stall2 !== 32'd0) begin
         n_fail++; $display("FAIL redirect_cnt: got flush %0d %0d stall %0d expected 1 1 0", flush1, flush2, stall2);
      end
   endtask

   // Back-to-back mispredicts: the second restarts the redirect window.
   task automatic test_back_to_back();
      int          kinds[4] = '{2, 2, 0, 0};
      logic [14:0] exps[4]  = '{{E_FL, E_FL, E_FL}, {E_FL, E_FL, E_FL},
                                {E_RUN, E_FL, E_RUN}, {E_RUN, E_RUN, E_RUN}};
      logic [14:0] e;
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(exps[i]);
         drive_kind(kinds[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (o_all !== e) begin
            n_fail++; $display("FAIL back_to_back_c%0d: got %b expected %b", i, o_all, e);
         end
      end
      n_checks++;
      if (flush1 !== 32'd2 || flush2 !== 32'd2 || flush3 !== 32'd2) begin
         n_fail++; $display("FAIL back_to_back_cnt: got %0d %0d %0d expected 2 2 2", flush1, flush2, flush3);
      end
   endtask

   // Mispredict aborting a stall, and mispredict coinciding with a hit.
   task automatic test_mispred_priority();
      int          kinds[6] = '{1, 0, 2, 0, 3, 0};
      logic [14:0] exps[6]  = '{{E_LU, E_LU, E_LU}, {E_RUN, E_LU, E_LU}, {E_FL, E_FL, E_FL},
                                {E_RUN, E_FL, E_RUN}, {E_FL, E_FL, E_FL}, {E_RUN, E_FL, E_RUN}};
      logic [14:0] e;
      reset_dut();
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(exps[i]);
         drive_kind(kinds[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (o_all !== e) begin
            n_fail++; $display("FAIL mispred_prio_c%0d: got %b expected %b", i, o_all, e);
         end
      end
      n_checks++;
      if (stall3 !== 32'd2 || flush3 !== 32'd2 || stall1 !== 32'd1 || stall2 !== 32'd2) begin
         n_fail++; $display("FAIL mispred_prio_cnt: got stall %0d %0d %0d flush3 %0d expected 1 2 2 2",
                            stall1, stall2, stall3, flush3);
      end
   endtask

   // Random traffic against a remaining-cycles model of the 2/2 instance.
   task automatic test_random();
      logic        v, u1s, u2s, ld, mp, lu;
      logic [4:0]  r1, r2, rd;
      logic [4:0]  m_out;
      logic [14:0] e;
      int          lu_left = 0, rd_left = 0, m_stall = 0, m_flush = 0;
      reset_dut();
      for (int i = 0; i < 300; i++) begin
         v   = ($urandom_range(0, 3) != 0);
         r1  = 5'($urandom_range(0, 3));
         r2  = 5'($urandom_range(0, 3));
         rd  = 5'($urandom_range(0, 3));
         u1s = 1'($urandom_range(0, 1));
         u2s = 1'($urandom_range(0, 1));
         ld  = 1'($urandom_range(0, 1));
         mp  = ($urandom_range(0, 9) == 0);
         lu  = v && ld && (rd != 5'd0) && ((u1s && r1 == rd) || (u2s && r2 == rd));
         if (mp) begin
            m_out = E_FL; rd_left = 1; lu_left = 0; m_flush++;
         end else if (rd_left > 0) begin
            m_out = E_FL; rd_left--;
         end else if (lu_left > 0) begin
            m_out = E_LU; lu_left--; m_stall++;
         end else if (lu) begin
            m_out = E_LU; lu_left = 1; m_stall++;
         end else begin
            m_out = E_RUN;
         end
         exp_q.push_back({5'd0, m_out, 5'd0});
         drive_raw(v, r1, r2, u1s, u2s, rd, ld, mp);
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (o2 !== e[9:5]) begin
            n_fail++; $display("FAIL random_c%0d: got %b expected %b", i, o2, e[9:5]);
         end
         n_checks++;
         if ((idf1 & fwd1) | (idf2 & fwd2) | (idf3 & fwd3) |
             (ife1 & iff1) | (ife2 & iff2) | (ife3 & iff3)) begin
            n_fail++; $display("FAIL random_exclusive_c%0d: got %b %b %b expected no flush overlap", i, o1, o2, o3);
         end
      end
      drive_kind(0);
      @(negedge clk);
      n_checks++;
      if (stall2 !== 32'(m_stall) || flush2 !== 32'(m_flush)) begin
         n_fail++; $display("FAIL random_cnt: got stall %0d flush %0d expected %0d %0d", stall2, flush2, m_stall, m_flush);
      end
   endtask

   initial begin
      rst = 1'b1;
      id_valid = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
      ex_rd_addr = 5'd0; ex_isload = 1'b0; ex_mispred = 1'b0;
      test_reset();
      test_load_use();
      test_no_stall();
      test_redirect();
      test_back_to_back();
      test_mispred_priority();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
